// File: rtl/cb_dina_map.sv
// rtl/cb_dina_map.sv - maps RSA/TB result rows onto CB port-A write lanes with sequenced row addresses
// Optional: CB_DINA_ZERO_FILL_EN makes NEW mode write all four lanes, zeroing the unselected pair.
module cb_dina_map #(
  parameter int X              = 4,
  parameter int L              = 4,
  parameter int RSA_DW         = 32,
  parameter int SEQ_CNT_DW     = 10,
  parameter int CB_AW          = 10,
  parameter int CB_DINA_SEL_DW = 5
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      start,
  input  logic [CB_DINA_SEL_DW-1:0] CB_dina_sel,
  input  logic                      l_k_0,
  input  logic [CB_AW-1:0]          base_addr,
  input  logic [SEQ_CNT_DW-1:0]     row_num,
  input  logic [X*RSA_DW-1:0]       RSA_dout,
  input  logic                      RSA_dout_vld,
  input  logic [X*RSA_DW-1:0]       TB_douta,
  input  logic                      TB_douta_vld,
  output logic                      CB_ena,
  output logic [L-1:0]              CB_wea,
  output logic [CB_AW-1:0]          CB_addra,
  output logic [L*RSA_DW-1:0]       CB_dina,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [2:0] SRC_RSA = 3'b001;
  localparam logic [2:0] SRC_TB  = 3'b010;
  localparam logic [1:0] DIR_POS = 2'b01;
  localparam logic [1:0] DIR_NEG = 2'b10;
  localparam logic [1:0] DIR_NEW = 2'b11;

  state_t                r_state, w_next;
  logic [2:0]            r_src;
  logic [1:0]            r_dir;
  logic                  r_lk0;
  logic [CB_AW-1:0]      r_base;
  logic [SEQ_CNT_DW-1:0] r_rows;
  logic [SEQ_CNT_DW-1:0] r_seq_cnt;

  logic                  w_src_vld;
  logic [X*RSA_DW-1:0]   w_row;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_write;
  logic [CB_AW-1:0]      w_addr;
  logic [L*RSA_DW-1:0]   w_dina;
  logic [L-1:0]          w_wea;

  // Only the latched source's valid counts; an IDLE/unknown source never produces a beat.
  always_comb begin
    w_src_vld = 1'b0;
    w_row     = RSA_dout;
    if (r_src == SRC_RSA) begin
      w_src_vld = RSA_dout_vld;
    end else if (r_src == SRC_TB) begin
      w_src_vld = TB_douta_vld;
      w_row     = TB_douta;
    end
  end

  assign w_beat  = (r_state == S_RUN) && w_src_vld;
  assign w_last  = w_beat && (r_seq_cnt == r_rows - SEQ_CNT_DW'(1));
  assign w_write = w_beat && (r_dir != 2'b00);
  assign w_addr  = r_base + CB_AW'(r_seq_cnt);

  always_comb begin
    w_dina = '0;
    w_wea  = '0;
    case (r_dir)
      DIR_POS: begin
        for (int i = 0; i < L; i++) w_dina[i*RSA_DW +: RSA_DW] = w_row[i*RSA_DW +: RSA_DW];
        w_wea = '1;
      end
      DIR_NEG: begin
        for (int i = 0; i < L; i++) w_dina[i*RSA_DW +: RSA_DW] = w_row[(L-1-i)*RSA_DW +: RSA_DW];
        w_wea = '1;
      end
      DIR_NEW: begin
        if (r_lk0) begin
          w_dina[0 +: 2*RSA_DW] = w_row[0 +: 2*RSA_DW];
          w_wea[1:0]            = 2'b11;
        end else begin
          w_dina[2*RSA_DW +: 2*RSA_DW] = w_row[0 +: 2*RSA_DW];
          w_wea[3:2]                   = 2'b11;
        end
`ifdef CB_DINA_ZERO_FILL_EN
        w_wea = '1;
`endif
      end
      default: begin
        w_dina = '0;
        w_wea  = '0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (row_num == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dir     <= '0;
      r_lk0     <= 1'b0;
      r_base    <= '0;
      r_rows    <= '0;
      r_seq_cnt <= '0;
      CB_ena    <= 1'b0;
      CB_wea    <= '0;
      CB_addra  <= '0;
      CB_dina   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_src     <= CB_dina_sel[4:2];
        r_dir     <= CB_dina_sel[1:0];
        r_lk0     <= l_k_0;
        r_base    <= base_addr;
        r_rows    <= row_num;
        r_seq_cnt <= '0;
      end else if (w_beat) begin
        r_seq_cnt <= r_seq_cnt + SEQ_CNT_DW'(1);
      end
      CB_ena   <= w_write;
      CB_wea   <= w_write ? w_wea  : '0;
      CB_addra <= w_write ? w_addr : '0;
      CB_dina  <= w_write ? w_dina : '0;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_cb_dina_map.sv
// tb/tb_cb_dina_map.sv - randomized self-checking bench for cb_dina_map against a lane-level model
// Honours CB_DINA_ZERO_FILL_EN in its expected NEW-mode write enables.
module tb_cb_dina_map;

  localparam int X = 4, L = 4, DW = 32, SW = 10, AW = 10, SELW = 5;

  logic              clk = 1'b0;
  logic              sys_rst;
  logic              start;
  logic [SELW-1:0]   CB_dina_sel;
  logic              l_k_0;
  logic [AW-1:0]     base_addr;
  logic [SW-1:0]     row_num;
  logic [X*DW-1:0]   RSA_dout;
  logic              RSA_dout_vld;
  logic [X*DW-1:0]   TB_douta;
  logic              TB_douta_vld;
  logic              CB_ena;
  logic [L-1:0]      CB_wea;
  logic [AW-1:0]     CB_addra;
  logic [L*DW-1:0]   CB_dina;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  cb_dina_map dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .CB_dina_sel(CB_dina_sel), .l_k_0(l_k_0),
    .base_addr(base_addr), .row_num(row_num), .RSA_dout(RSA_dout), .RSA_dout_vld(RSA_dout_vld),
    .TB_douta(TB_douta), .TB_douta_vld(TB_douta_vld), .CB_ena(CB_ena), .CB_wea(CB_wea),
    .CB_addra(CB_addra), .CB_dina(CB_dina), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_wr     = 0;

  // model: transaction in progress, done cycle pending, and the latched transaction fields
  bit m_run = 0, m_done = 0, m_lk0 = 0;
  int m_cnt = 0, m_rows = 0, m_base = 0, m_src = 0, m_dir = 0;

  task automatic check(input string tag, input logic [L*DW-1:0] got, input logic [L*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [X*DW-1:0] lanes(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic void map_row(input int dir, input bit lk0, input logic [X*DW-1:0] row,
                                  output logic [L*DW-1:0] dina, output logic [L-1:0] wea);
    logic [31:0] s[4];
    logic [31:0] o[4];
    int b;
    for (int i = 0; i < 4; i++) begin
      s[i] = row[i*DW +: DW];
      o[i] = '0;
    end
    wea = '0;
    case (dir)
      1: begin for (int i = 0; i < 4; i++) o[i] = s[i];     wea = 4'hF; end
      2: begin for (int i = 0; i < 4; i++) o[i] = s[3 - i]; wea = 4'hF; end
      3: begin
        b = lk0 ? 0 : 2;
        o[b] = s[0];
        o[b + 1] = s[1];
        wea = lk0 ? 4'h3 : 4'hC;
`ifdef CB_DINA_ZERO_FILL_EN
        wea = 4'hF;
`endif
      end
      default: wea = '0;
    endcase
    for (int i = 0; i < 4; i++) dina[i*DW +: DW] = o[i];
  endfunction

  // One clock: drive inputs, advance the model, then compare the registered outputs.
  task automatic step(input bit rst, input bit st, input bit rv, input bit tv);
    bit beat, next_done, e_ena;
    logic [L*DW-1:0] e_dina;
    logic [L-1:0] e_wea;
    int e_addr;
    sys_rst = rst; start = st; RSA_dout_vld = rv; TB_douta_vld = tv;
    e_ena = 0; e_dina = '0; e_wea = '0; e_addr = 0; next_done = 0;
    if (rst) begin
      m_run = 0;
      m_done = 0;
    end else begin
      beat = m_run && ((m_src == 1 && rv) || (m_src == 2 && tv));
      if (beat) begin
        if (m_dir != 0) begin
          e_ena = 1;
          map_row(m_dir, m_lk0, (m_src == 2) ? TB_douta : RSA_dout, e_dina, e_wea);
          e_addr = (m_base + m_cnt) % 1024;
        end
        m_cnt++;
        if (m_cnt == m_rows) begin
          m_run = 0;
          next_done = 1;
        end
      end else if (!m_run && !m_done && st) begin
        m_src = int'(CB_dina_sel[4:2]); m_dir = int'(CB_dina_sel[1:0]); m_lk0 = l_k_0;
        m_base = int'(base_addr); m_rows = int'(row_num); m_cnt = 0;
        if (m_rows == 0) next_done = 1;
        else m_run = 1;
      end
      m_done = next_done;
    end
    @(posedge clk);
    #1;
    check("ena", CB_ena, e_ena);
    check("wea", CB_wea, e_wea);
    check("dina", CB_dina, e_dina);
    if (e_ena) check("addra", CB_addra, e_addr[AW-1:0]);
    check("busy", busy, m_run || m_done);
    check("done", done, m_done);
    if (CB_ena) n_wr++;
  endtask

  task automatic begin_txn(input logic [4:0] sel, input bit lk0, input int base, input int rows);
    CB_dina_sel = sel; l_k_0 = lk0; base_addr = AW'(base); row_num = SW'(rows);
    n_wr = 0;
    step(0, 1, 0, 0);
  endtask

  initial begin
    int guard;
    sys_rst = 1; start = 0; CB_dina_sel = '0; l_k_0 = 0; base_addr = '0; row_num = '0;
    RSA_dout = '0; RSA_dout_vld = 0; TB_douta = '0; TB_douta_vld = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_addra", CB_addra, 0);

    // POS from RSA
    RSA_dout = lanes(4, 3, 2, 1);
    begin_txn(5'b00101, 0, 5, 3);
    repeat (3) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("pos_writes", n_wr, 3);

    // NEG from TB, RSA valid ignored
    TB_douta = lanes(1, 2, 3, 4);
    RSA_dout = lanes(9, 9, 9, 9);
    begin_txn(5'b01010, 0, 20, 2);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    check("neg_writes", n_wr, 2);

    // NEW, both lane pairs
    RSA_dout = lanes(7, 32'hFFFF_FFF8, 99, 55);
    for (int k = 0; k < 2; k++) begin
      begin_txn(5'b00111, k[0], 40, 1);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("new_writes", n_wr, 1);
    end

    // rows=0: done next cycle, no writes
    begin_txn(5'b00101, 0, 7, 0);
    step(0, 0, 1, 0);
    check("rows0_writes", n_wr, 0);

    // address wrap plus start-while-busy ignored
    RSA_dout = lanes(11, 12, 13, 14);
    begin_txn(5'b00101, 0, 1023, 2);
    CB_dina_sel = 5'b01010; base_addr = 10'd3; row_num = 10'd9;
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    check("wrap_writes", n_wr, 2);

    // reset mid-run, then a fresh transaction
    RSA_dout = lanes(21, 22, 23, 24);
    begin_txn(5'b00110, 0, 300, 4);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    begin_txn(5'b00101, 0, 100, 2);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("fresh_writes", n_wr, 2);

    // gapped beats
    begin_txn(5'b00101, 0, 50, 2);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("gap_writes", n_wr, 2);

    // IDLE source: stays busy, never writes, cleared by reset
    begin_txn(5'b00001, 0, 60, 3);
    repeat (5) step(0, 0, 1, 1);
    check("noop_writes", n_wr, 0);
    step(1, 0, 0, 0);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [4:0] sel;
      int rows;
      sel[4:2] = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
      sel[1:0] = 2'($urandom_range(1, 3));
      rows = $urandom_range(0, 6);
      begin_txn(sel, 1'($urandom_range(0, 1)), $urandom_range(0, 1023), rows);
      guard = 0;
      while ((m_run || m_done) && guard < 200) begin
        RSA_dout = {$urandom, $urandom, $urandom, $urandom};
        TB_douta = {$urandom, $urandom, $urandom, $urandom};
        CB_dina_sel = 5'($urandom);
        row_num = SW'($urandom_range(0, 5));
        step(0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        guard++;
      end
      check("txn_timeout", guard < 200, 1);
      check("rand_writes", n_wr, ((sel[1:0] != 2'b00) ? rows : 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
